// File: rtl/i2c_apb_arbiter.sv
// Two-requester round-robin APB master in front of the I2C controller register port.
// One access in flight at a time; a watchdog aborts ACCESS phases that never see pready_i.
module i2c_apb_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                   pclk_i,
    input  logic                   preset_i,
    input  logic [1:0]             req_valid_i,
    input  logic [1:0]             req_write_i,
    input  logic [2*ADDR_SIZE-1:0] req_addr_i,
    input  logic [2*DATA_SIZE-1:0] req_wdata_i,
    output logic [1:0]             req_ack_o,
    output logic [1:0]             rsp_valid_o,
    output logic                   rsp_err_o,
    output logic [DATA_SIZE-1:0]   rsp_rdata_o,
    output logic [ADDR_SIZE-1:0]   paddr_o,
    output logic                   pwrite_o,
    output logic                   psel_o,
    output logic                   penable_o,
    output logic [DATA_SIZE-1:0]   pwdata_o,
    input  logic [DATA_SIZE-1:0]   prdata_i,
    input  logic                   pready_i
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    // Abort fires on the TIMEOUT-th stalled ACCESS cycle, i.e. when the count is one short.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
    localparam bit         WD_EN   = (TIMEOUT != 0);

    logic [1:0] state;
    logic       grant;
    logic       last_grant;
    logic       pick;
    logic [7:0] wd_cnt;
    logic       wd_expire;

    always_comb begin
        pick = 1'b0;
        case (req_valid_i)
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_grant;
            default: pick = 1'b0;
        endcase
    end

    assign wd_expire = WD_EN && (wd_cnt == WD_LAST);

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            wd_cnt      <= '0;
            req_ack_o   <= '0;
            rsp_valid_o <= '0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            paddr_o     <= '0;
            pwrite_o    <= 1'b0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwdata_o    <= '0;
        end else begin
            req_ack_o   <= '0;
            rsp_valid_o <= '0;
            case (state)
                IDLE: begin
                    if (|req_valid_i) begin
                        grant           <= pick;
                        paddr_o         <= pick ? req_addr_i[2*ADDR_SIZE-1:ADDR_SIZE]
                                                : req_addr_i[ADDR_SIZE-1:0];
                        pwdata_o        <= pick ? req_wdata_i[2*DATA_SIZE-1:DATA_SIZE]
                                                : req_wdata_i[DATA_SIZE-1:0];
                        pwrite_o        <= req_write_i[pick];
                        req_ack_o[pick] <= 1'b1;
                        psel_o          <= 1'b1;
                        state           <= SETUP;
                    end
                end
                SETUP: begin
                    penable_o <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // A late pready_i still wins over an abort in the same cycle.
                    if (pready_i) begin
                        psel_o             <= 1'b0;
                        penable_o          <= 1'b0;
                        rsp_rdata_o        <= pwrite_o ? '0 : prdata_i;
                        rsp_err_o          <= 1'b0;
                        rsp_valid_o[grant] <= 1'b1;
                        state              <= RESP;
                    end else if (wd_expire) begin
                        psel_o             <= 1'b0;
                        penable_o          <= 1'b0;
                        rsp_rdata_o        <= '0;
                        rsp_err_o          <= 1'b1;
                        rsp_valid_o[grant] <= 1'b1;
                        state              <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                default: begin
                    last_grant <= grant;
                    wd_cnt     <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_apb_arbiter.sv
// Randomized self-checking bench for i2c_apb_arbiter; a transaction-level model predicts
// grant, APB phase length, error and read data from the arbitration and watchdog rules.
module tb_i2c_apb_arbiter;

    localparam int T = 4;

    logic        pclk = 1'b0;
    logic        preset;
    logic [1:0]  req_valid, req_write, req_valid_nw;
    logic [15:0] req_addr, req_wdata;
    logic [7:0]  prdata;
    logic        pready, pready_nw;

    logic [1:0]  req_ack, rsp_valid, req_ack_nw, rsp_valid_nw;
    logic        rsp_err, pwrite, psel, penable;
    logic        rsp_err_nw, pwrite_nw, psel_nw, penable_nw;
    logic [7:0]  rsp_rdata, paddr, pwdata, rsp_rdata_nw, paddr_nw, pwdata_nw;

    int   n_pass = 0;
    int   n_total = 0;
    logic m_last = 1'b1;

    always #5 pclk = ~pclk;

    i2c_apb_arbiter #(.DATA_SIZE(8), .ADDR_SIZE(8), .TIMEOUT(T)) dut (
        .pclk_i(pclk), .preset_i(preset), .req_valid_i(req_valid), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_ack_o(req_ack),
        .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_rdata_o(rsp_rdata),
        .paddr_o(paddr), .pwrite_o(pwrite), .psel_o(psel), .penable_o(penable),
        .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready)
    );

    i2c_apb_arbiter #(.DATA_SIZE(8), .ADDR_SIZE(8), .TIMEOUT(0)) dut_nw (
        .pclk_i(pclk), .preset_i(preset), .req_valid_i(req_valid_nw), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_ack_o(req_ack_nw),
        .rsp_valid_o(rsp_valid_nw), .rsp_err_o(rsp_err_nw), .rsp_rdata_o(rsp_rdata_nw),
        .paddr_o(paddr_nw), .pwrite_o(pwrite_nw), .psel_o(psel_nw), .penable_o(penable_nw),
        .pwdata_o(pwdata_nw), .prdata_i(prdata), .pready_i(pready_nw)
    );

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge pclk);
        preset = 1'b1; req_valid = 2'b00; pready = 1'b0; req_valid_nw = 2'b00; pready_nw = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        preset = 1'b0;
        m_last = 1'b1;
    endtask

    // One full transaction; the bench plays the APB slave with 'waits' stalled ACCESS cycles.
    task automatic run_xfer(input logic [1:0] mask, input int waits, input logic [7:0] rdv,
                            input string tag);
        logic       g, ewr, eerr;
        logic [7:0] ea, ew, erd;
        int         n, en;
        g    = (mask == 2'b11) ? ~m_last : mask[1];
        ea   = g ? req_addr[15:8]  : req_addr[7:0];
        ew   = g ? req_wdata[15:8] : req_wdata[7:0];
        ewr  = req_write[g];
        eerr = (T != 0) && (waits >= T);
        en   = eerr ? T : waits + 1;
        erd  = (eerr || ewr) ? 8'h00 : rdv;
        @(negedge pclk);
        req_valid = mask; pready = 1'b0; prdata = rdv;
        n = 0;
        do begin @(posedge pclk); #1; n++; end while (req_ack === 2'b00 && n < 8);
        n_total++; if (n !== 1) $display("FAIL %s_ack_lat: got %0d cycles want 1", tag, n); else n_pass++;
        n_total++; if (req_ack !== (2'b01 << g)) $display("FAIL %s_ack: got %b want %b", tag, req_ack, 2'b01 << g); else n_pass++;
        n_total++; if ({psel, penable} !== 2'b10) $display("FAIL %s_setup: got %b want 10", tag, {psel, penable}); else n_pass++;
        @(negedge pclk);
        req_valid = 2'b00; req_addr = 16'($urandom); req_wdata = 16'($urandom); req_write = 2'($urandom);
        @(posedge pclk); #1;
        n = 1;
        while (n <= 40) begin
            n_total++;
            if ({psel, penable, paddr, pwrite, pwdata} !== {2'b11, ea, ewr, ew})
                $display("FAIL %s_apb: got %b/%h/%b/%h want 11/%h/%b/%h", tag, {psel, penable}, paddr, pwrite, pwdata, ea, ewr, ew);
            else n_pass++;
            @(negedge pclk);
            pready = (n > waits);
            @(posedge pclk); #1;
            if (rsp_valid !== 2'b00) break;
            n++;
        end
        n_total++; if (n !== en) $display("FAIL %s_access_len: got %0d want %0d", tag, n, en); else n_pass++;
        n_total++; if (rsp_valid !== (2'b01 << g)) $display("FAIL %s_rsp_valid: got %b want %b", tag, rsp_valid, 2'b01 << g); else n_pass++;
        n_total++; if (rsp_err !== eerr) $display("FAIL %s_rsp_err: got %b want %b", tag, rsp_err, eerr); else n_pass++;
        n_total++; if (rsp_rdata !== erd) $display("FAIL %s_rdata: got %h want %h", tag, rsp_rdata, erd); else n_pass++;
        n_total++; if ({psel, penable} !== 2'b00) $display("FAIL %s_resp_bus: got %b want 00", tag, {psel, penable}); else n_pass++;
        @(negedge pclk);
        pready = 1'b0;
        @(posedge pclk); #1;
        n_total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b00, eerr, erd})
            $display("FAIL %s_hold: got %b/%b/%h want 00/%b/%h", tag, rsp_valid, rsp_err, rsp_rdata, eerr, erd);
        else n_pass++;
        m_last = g;
    endtask

    task automatic test_reset();
        preset = 1'b1; req_valid = 2'b11; req_valid_nw = 2'b11; pready = 1'b1; pready_nw = 1'b1;
        req_write = 2'b11; req_addr = 16'hA5A5; req_wdata = 16'h5A5A; prdata = 8'hFF;
        repeat (2) @(posedge pclk);
        #1;
        n_total++;
        if ({req_ack, rsp_valid, rsp_err, rsp_rdata, paddr, pwrite, psel, penable, pwdata} !== '0)
            $display("FAIL reset_outputs: got %h want 0", {req_ack, rsp_valid, rsp_err, rsp_rdata, paddr, pwrite, psel, penable, pwdata});
        else n_pass++;
        n_total++;
        if ({req_ack_nw, rsp_valid_nw, rsp_err_nw, rsp_rdata_nw, paddr_nw, pwrite_nw, psel_nw, penable_nw, pwdata_nw} !== '0)
            $display("FAIL reset_outputs_nw: got %h want 0", {req_ack_nw, rsp_valid_nw, rsp_err_nw, rsp_rdata_nw, paddr_nw, pwrite_nw, psel_nw, penable_nw, pwdata_nw});
        else n_pass++;
        @(negedge pclk);
        preset = 1'b0; req_valid = 2'b00; req_valid_nw = 2'b00; pready = 1'b0; pready_nw = 1'b0;
        m_last = 1'b1;
    endtask

    task automatic test_single_write();
        req_write = 2'b01; req_addr = 16'h7702; req_wdata = 16'h115A;
        run_xfer(2'b01, 0, 8'hEE, "single_wr");
    endtask

    task automatic test_wait_read();
        req_write = 2'b00; req_addr = 16'h0533; req_wdata = 16'h9944;
        run_xfer(2'b10, 3, 8'hC3, "wait_rd");
    endtask

    task automatic test_boundary();
        req_write = 2'b01; req_addr = 16'h1122; req_wdata = 16'h3344;
        run_xfer(2'b01, T - 1, 8'h77, "wd_edge");
    endtask

    task automatic test_watchdog();
        req_write = 2'b00; req_addr = 16'h0A0B; req_wdata = 16'h0C0D;
        run_xfer(2'b01, 50, 8'h99, "wd_abort");
        req_write = 2'b00; req_addr = 16'h1E2F; req_wdata = 16'h0000;
        run_xfer(2'b11, 0, 8'h42, "after_abort");
    endtask

    task automatic test_no_watchdog();
        int n, bad;
        req_write = 2'b00; req_addr = 16'h0009; prdata = 8'h3C;
        @(negedge pclk);
        req_valid_nw = 2'b01; pready_nw = 1'b0;
        n = 0;
        do begin @(posedge pclk); #1; n++; end while (req_ack_nw === 2'b00 && n < 8);
        n_total++; if (req_ack_nw !== 2'b01) $display("FAIL nowd_ack: got %b want 01", req_ack_nw); else n_pass++;
        @(negedge pclk);
        req_valid_nw = 2'b00;
        @(posedge pclk); #1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if ({psel_nw, penable_nw, rsp_valid_nw} !== 4'b1100) bad++;
            @(posedge pclk); #1;
        end
        n_total++; if (bad !== 0) $display("FAIL nowd_hold: got %0d bad cycles want 0", bad); else n_pass++;
        @(negedge pclk);
        pready_nw = 1'b1;
        @(posedge pclk); #1;
        n_total++;
        if ({rsp_valid_nw, rsp_err_nw, rsp_rdata_nw} !== {2'b01, 1'b0, 8'h3C})
            $display("FAIL nowd_rsp: got %b/%b/%h want 01/0/3c", rsp_valid_nw, rsp_err_nw, rsp_rdata_nw);
        else n_pass++;
        @(negedge pclk);
        pready_nw = 1'b0;
        repeat (2) @(posedge pclk);
    endtask

    task automatic test_round_robin();
        int   cyc, nrsp, bad, r0, r1;
        int   ack_cyc[$];
        logic order[$];
        do_reset();
        req_write = 2'b00; req_addr = 16'h0201; prdata = 8'h10;
        @(negedge pclk);
        req_valid = 2'b11; pready = 1'b1;
        cyc = 0; nrsp = 0; bad = 0; r0 = 0; r1 = 0;
        while (cyc < 40 && nrsp < 4) begin
            @(posedge pclk); #1; cyc++;
            if (req_ack !== 2'b00) begin order.push_back(req_ack[1]); ack_cyc.push_back(cyc); end
            if (rsp_valid[0] === 1'b1) r0++;
            if (rsp_valid[1] === 1'b1) r1++;
            if (rsp_valid !== 2'b00) nrsp++;
            if (req_ack !== 2'b00 && rsp_valid !== 2'b00 && req_ack !== rsp_valid) bad++;
        end
        @(negedge pclk);
        req_valid = 2'b00; pready = 1'b0;
        @(posedge pclk); #1;
        n_total++;
        if (order.size() !== 4 || order[0] !== 1'b0 || order[1] !== 1'b1 || order[2] !== 1'b0 || order[3] !== 1'b1)
            $display("FAIL rr_order: got %0d grants want order 0,1,0,1", order.size());
        else n_pass++;
        n_total++; if (r0 !== 2 || r1 !== 2) $display("FAIL rr_counts: got %0d/%0d want 2/2", r0, r1); else n_pass++;
        n_total++;
        if (ack_cyc.size() !== 4 || ack_cyc[1] - ack_cyc[0] !== 4 || ack_cyc[3] - ack_cyc[2] !== 4)
            $display("FAIL rr_spacing: got %0d acks want 4 spaced 4 cycles", ack_cyc.size());
        else n_pass++;
        n_total++; if (bad !== 0) $display("FAIL rr_overlap: got %0d want 0", bad); else n_pass++;
        m_last = 1'b1;
    endtask

    task automatic test_reset_mid_access();
        int n, seen;
        req_write = 2'b00; req_addr = 16'h4433; req_wdata = 16'h0000;
        @(negedge pclk);
        req_valid = 2'b01; pready = 1'b0;
        n = 0;
        do begin @(posedge pclk); #1; n++; end while (req_ack === 2'b00 && n < 8);
        @(negedge pclk);
        req_valid = 2'b00;
        @(posedge pclk); #1;
        n_total++; if ({psel, penable} !== 2'b11) $display("FAIL rst_pre: got %b want 11", {psel, penable}); else n_pass++;
        @(negedge pclk);
        preset = 1'b1;
        @(posedge pclk); #1;
        n_total++;
        if ({req_ack, rsp_valid, rsp_err, rsp_rdata, paddr, pwrite, psel, penable, pwdata} !== '0)
            $display("FAIL rst_mid: got %h want 0", {req_ack, rsp_valid, rsp_err, rsp_rdata, paddr, pwrite, psel, penable, pwdata});
        else n_pass++;
        @(negedge pclk);
        preset = 1'b0; pready = 1'b1;
        m_last = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge pclk); #1;
            if (rsp_valid !== 2'b00 || req_ack !== 2'b00 || psel !== 1'b0) seen++;
        end
        n_total++; if (seen !== 0) $display("FAIL rst_ghost: got %0d active cycles want 0", seen); else n_pass++;
        pready = 1'b0;
        req_write = 2'b10; req_addr = 16'h6655; req_wdata = 16'hBBAA;
        run_xfer(2'b11, 1, 8'h5D, "rst_rr");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            req_write = 2'($urandom);
            req_addr  = 16'($urandom);
            req_wdata = 16'($urandom);
            run_xfer(2'($urandom_range(1, 3)), int'($urandom_range(0, 6)), 8'($urandom), "rand");
        end
    endtask

    initial begin
        req_valid = 2'b00; req_valid_nw = 2'b00; pready = 1'b0; pready_nw = 1'b0;
        req_write = 2'b00; req_addr = '0; req_wdata = '0; prdata = '0; preset = 1'b1;
        test_reset();
        test_single_write();
        test_wait_read();
        test_boundary();
        test_watchdog();
        test_no_watchdog();
        test_round_robin();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
